// File: rtl/dsp_file_engine_if.sv
// File bus between the DSP equation blocks (master) and the file engine (slave).
// Handshake: a rising edge of file_read/file_write starts one transfer; file_active stays high until it completes.
interface dsp_file_engine_if #(
    parameter int NUM_FILES = 4
);
    logic [7:0]           file_num;
    logic                 file_read;
    logic                 file_write;
    logic [31:0]          file_write_data;
    logic                 file_clear;
    logic [31:0]          file_read_data;
    logic                 file_active;
    logic                 file_error;
    logic [NUM_FILES-1:0] file_empty;
    logic [NUM_FILES-1:0] file_full;
    logic [2:0]           fsm_state;

    modport master (
        output file_num, file_read, file_write, file_write_data, file_clear,
        input  file_read_data, file_active, file_error, file_empty, file_full, fsm_state
    );

    modport slave (
        input  file_num, file_read, file_write, file_write_data, file_clear,
        output file_read_data, file_active, file_error, file_empty, file_full, fsm_state
    );
endinterface

// File: rtl/dsp_file_engine.sv
// NUM_FILES independent circular FIFOs of 32-bit words sharing one sync-read RAM,
// serviced one request at a time from edges on file_read / file_write.
module dsp_file_engine #(
    parameter int NUM_FILES = 4,
    parameter int DEPTH     = 16,
    parameter int AW        = 4
) (
    input  logic               wb_clk,
    input  logic               wb_rst_n,
    dsp_file_engine_if.slave   bus
);
    localparam int FW        = (NUM_FILES > 1) ? $clog2(NUM_FILES) : 1;
    localparam int ADW       = FW + AW;
    localparam int RAM_WORDS = 2 ** ADW;
    localparam logic [7:0]    NF8      = NUM_FILES[7:0];
    localparam logic [AW:0]   FULL_CNT = DEPTH[AW:0];
    localparam logic [AW:0]   CNT_ONE  = 1;
    localparam logic [AW-1:0] PTR_ONE  = 1;

    typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR, ERR} state_t;

    state_t          state, state_n;
    logic            prev_rd, prev_wr;
    logic            start_rd, start_wr;
    logic            go_rd, go_wr, go_err;
    logic            req_ok;
    logic [FW-1:0]   req_idx;
    logic [AW:0]     req_count;
    logic [FW-1:0]   fnum_q;
    logic [31:0]     wdata_q;
    logic [31:0]     ram_q;
    logic [31:0]     read_data_q;
    logic            error_q;
    logic [AW-1:0]   rd_ptr [NUM_FILES];
    logic [AW-1:0]   wr_ptr [NUM_FILES];
    logic [AW:0]     count  [NUM_FILES];
    logic [31:0]     mem    [RAM_WORDS];
    logic [ADW-1:0]  rd_addr, wr_addr;
    logic            ram_we;

    always_comb begin
        start_rd  = bus.file_read  & ~prev_rd;
        start_wr  = bus.file_write & ~prev_wr;
        req_ok    = bus.file_num < NF8;
        req_idx   = bus.file_num[FW-1:0];
        req_count = count[req_idx];
        go_rd     = 1'b0;
        go_wr     = 1'b0;
        go_err    = 1'b0;
        state_n   = state;
        case (state)
            IDLE: begin
                // Simultaneous edges are ambiguous, so neither is performed.
                if (start_rd && start_wr) begin
                    go_err = 1'b1;
                end else if (start_rd) begin
                    if (!req_ok || req_count == '0) go_err = 1'b1;
                    else                            go_rd  = 1'b1;
                end else if (start_wr) begin
                    if (!req_ok || req_count == FULL_CNT) go_err = 1'b1;
                    else                                  go_wr  = 1'b1;
                end
                if (go_rd)       state_n = RD_ADDR;
                else if (go_wr)  state_n = WR;
                else if (go_err) state_n = ERR;
            end
            RD_ADDR: state_n = RD_DATA;
            RD_DATA: state_n = IDLE;
            WR:      state_n = IDLE;
            ERR:     state_n = IDLE;
            default: state_n = IDLE;
        endcase
        if (bus.file_clear) state_n = IDLE;
    end

    always_ff @(posedge wb_clk or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            state       <= IDLE;
            prev_rd     <= 1'b0;
            prev_wr     <= 1'b0;
            fnum_q      <= '0;
            wdata_q     <= '0;
            read_data_q <= '0;
            error_q     <= 1'b0;
            for (int f = 0; f < NUM_FILES; f++) begin
                rd_ptr[f] <= '0;
                wr_ptr[f] <= '0;
                count[f]  <= '0;
            end
        end else begin
            state   <= state_n;
            prev_rd <= bus.file_read;
            prev_wr <= bus.file_write;
            // Clear aborts any transfer before it can commit a pointer update.
            if (bus.file_clear) begin
                for (int f = 0; f < NUM_FILES; f++) begin
                    rd_ptr[f] <= '0;
                    wr_ptr[f] <= '0;
                    count[f]  <= '0;
                end
            end else begin
                if (go_rd || go_wr) begin
                    fnum_q  <= req_idx;
                    wdata_q <= bus.file_write_data;
                    error_q <= 1'b0;
                end
                if (go_err) error_q <= 1'b1;
                if (state == RD_DATA) begin
                    read_data_q    <= ram_q;
                    rd_ptr[fnum_q] <= rd_ptr[fnum_q] + PTR_ONE;
                    count[fnum_q]  <= count[fnum_q] - CNT_ONE;
                end
                if (state == WR) begin
                    wr_ptr[fnum_q] <= wr_ptr[fnum_q] + PTR_ONE;
                    count[fnum_q]  <= count[fnum_q] + CNT_ONE;
                end
            end
        end
    end

    always_comb begin
        rd_addr = {fnum_q, rd_ptr[fnum_q]};
        wr_addr = {fnum_q, wr_ptr[fnum_q]};
        ram_we  = (state == WR) && !bus.file_clear;
    end

    // RAM contents carry no reset; only pointers and counts define what is valid.
    always_ff @(posedge wb_clk) begin
        if (ram_we) mem[wr_addr] <= wdata_q;
        ram_q <= mem[rd_addr];
    end

    assign bus.file_active    = (state != IDLE) | ((start_rd | start_wr) & (state == IDLE));
    assign bus.file_read_data = read_data_q;
    assign bus.file_error     = error_q;
    assign bus.fsm_state      = state;

    for (genvar f = 0; f < NUM_FILES; f++) begin : g_flags
        assign bus.file_empty[f] = (count[f] == '0);
        assign bus.file_full[f]  = (count[f] == FULL_CNT);
    end
endmodule

// File: tb/tb_dsp_file_engine.sv
// Bench for dsp_file_engine: constant vector table, multi-cycle corner sequences,
// and random traffic against a queue-per-file model.
module tb_dsp_file_engine;
    localparam int NF = 4;

    logic wb_clk = 1'b0;
    logic wb_rst_n = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    dsp_file_engine_if #(.NUM_FILES(NF)) bus ();

    dsp_file_engine #(.NUM_FILES(NF), .DEPTH(16), .AW(4)) dut (
        .wb_clk   (wb_clk),
        .wb_rst_n (wb_rst_n),
        .bus      (bus)
    );

    always #5 wb_clk = ~wb_clk;

    typedef struct {
        bit          rd;
        bit          wr;
        logic [7:0]  fnum;
        logic [31:0] data;
        int          exp_act;
        bit          exp_err;
        logic [31:0] exp_rdata;
        logic [3:0]  exp_empty;
        logic [3:0]  exp_full;
    } vec_t;

    vec_t        vecs [12];
    logic [31:0] model_q [NF][$];
    logic [31:0] m_rdata;
    bit          m_err;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic logic [3:0] m_empty();
        logic [3:0] r;
        for (int f = 0; f < NF; f++) r[f] = (model_q[f].size() == 0);
        return r;
    endfunction

    function automatic logic [3:0] m_full();
        logic [3:0] r;
        for (int f = 0; f < NF; f++) r[f] = (model_q[f].size() == 16);
        return r;
    endfunction

    // One request: raise the level(s), count active cycles (bounded), then drop them.
    task automatic xfer(input bit rd, input bit wr, input logic [7:0] fnum,
                        input logic [31:0] data, output int act);
        @(posedge wb_clk); #1;
        bus.file_num        = fnum;
        bus.file_write_data = data;
        bus.file_read       = rd;
        bus.file_write      = wr;
        act = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge wb_clk);
            if (i == 1) begin
                bus.file_num        = 8'($urandom);
                bus.file_write_data = $urandom;
            end
            if (!bus.file_active) break;
            act++;
        end
        bus.file_read  = 1'b0;
        bus.file_write = 1'b0;
    endtask

    task automatic run_model(input bit rd, input bit wr, input logic [7:0] fnum,
                             input logic [31:0] data, input string tag);
        int exp_act, act, fi;
        fi = (fnum < NF) ? int'(fnum) : 0;
        if ((rd && wr) || fnum >= NF || (rd && model_q[fi].size() == 0) ||
            (wr && model_q[fi].size() == 16)) begin
            m_err = 1'b1;
            exp_act = 2;
        end else if (rd) begin
            m_rdata = model_q[fi].pop_front();
            m_err = 1'b0;
            exp_act = 3;
        end else begin
            model_q[fi].push_back(data);
            m_err = 1'b0;
            exp_act = 2;
        end
        xfer(rd, wr, fnum, data, act);
        chk({tag, " active"}, act, exp_act);
        chk({tag, " error"}, {31'b0, bus.file_error}, {31'b0, m_err});
        chk({tag, " rdata"}, bus.file_read_data, m_rdata);
        chk({tag, " empty"}, {28'b0, bus.file_empty}, {28'b0, m_empty()});
        chk({tag, " full"}, {28'b0, bus.file_full}, {28'b0, m_full()});
    endtask

    task automatic pulse_clear();
        @(posedge wb_clk); #1;
        bus.file_clear = 1'b1;
        @(posedge wb_clk); #1;
        bus.file_clear = 1'b0;
        for (int f = 0; f < NF; f++) model_q[f].delete();
    endtask

    initial begin
        int act;
        logic [31:0] word;
        vecs[0]  = '{1'b0, 1'b1, 8'd2, 32'hA5A5_0001, 2, 1'b0, 32'h0,         4'b1011, 4'b0};
        vecs[1]  = '{1'b0, 1'b1, 8'd0, 32'h1,         2, 1'b0, 32'h0,         4'b1010, 4'b0};
        vecs[2]  = '{1'b0, 1'b1, 8'd0, 32'h2,         2, 1'b0, 32'h0,         4'b1010, 4'b0};
        vecs[3]  = '{1'b0, 1'b1, 8'd0, 32'h3,         2, 1'b0, 32'h0,         4'b1010, 4'b0};
        vecs[4]  = '{1'b1, 1'b0, 8'd0, 32'h0,         3, 1'b0, 32'h1,         4'b1010, 4'b0};
        vecs[5]  = '{1'b1, 1'b0, 8'd0, 32'h0,         3, 1'b0, 32'h2,         4'b1010, 4'b0};
        vecs[6]  = '{1'b1, 1'b0, 8'd0, 32'h0,         3, 1'b0, 32'h3,         4'b1011, 4'b0};
        vecs[7]  = '{1'b1, 1'b0, 8'd1, 32'h0,         2, 1'b1, 32'h3,         4'b1011, 4'b0};
        vecs[8]  = '{1'b0, 1'b1, 8'd7, 32'h55,        2, 1'b1, 32'h3,         4'b1011, 4'b0};
        vecs[9]  = '{1'b1, 1'b0, 8'd2, 32'h0,         3, 1'b0, 32'hA5A5_0001, 4'b1111, 4'b0};
        vecs[10] = '{1'b1, 1'b1, 8'd2, 32'h77,        2, 1'b1, 32'hA5A5_0001, 4'b1111, 4'b0};
        vecs[11] = '{1'b0, 1'b1, 8'd1, 32'hDEAD_BEEF, 2, 1'b0, 32'hA5A5_0001, 4'b1101, 4'b0};

        bus.file_num = '0; bus.file_read = 1'b0; bus.file_write = 1'b0;
        bus.file_write_data = '0; bus.file_clear = 1'b0;
        repeat (3) @(posedge wb_clk);
        #1 wb_rst_n = 1'b1;
        @(negedge wb_clk);
        chk("reset active", {31'b0, bus.file_active}, 32'h0);
        chk("reset rdata", bus.file_read_data, 32'h0);
        chk("reset error", {31'b0, bus.file_error}, 32'h0);
        chk("reset empty", {28'b0, bus.file_empty}, 32'hF);
        chk("reset full", {28'b0, bus.file_full}, 32'h0);

        for (int v = 0; v < 12; v++) begin
            xfer(vecs[v].rd, vecs[v].wr, vecs[v].fnum, vecs[v].data, act);
            chk($sformatf("vec%0d active", v), act, vecs[v].exp_act);
            chk($sformatf("vec%0d error", v), {31'b0, bus.file_error}, {31'b0, vecs[v].exp_err});
            chk($sformatf("vec%0d rdata", v), bus.file_read_data, vecs[v].exp_rdata);
            chk($sformatf("vec%0d empty", v), {28'b0, bus.file_empty}, {28'b0, vecs[v].exp_empty});
            chk($sformatf("vec%0d full", v), {28'b0, bus.file_full}, {28'b0, vecs[v].exp_full});
        end

        m_rdata = 32'hA5A5_0001;
        m_err   = 1'b0;
        pulse_clear();
        @(negedge wb_clk);
        chk("clear empty", {28'b0, bus.file_empty}, 32'hF);

        // Pointer wrap: 8 in/out, then fill to full, overflow, drain, underflow.
        for (int i = 0; i < 8; i++)  run_model(1'b0, 1'b1, 8'd3, $urandom, "wrap wr8");
        for (int i = 0; i < 8; i++)  run_model(1'b1, 1'b0, 8'd3, 32'h0, "wrap rd8");
        for (int i = 0; i < 16; i++) run_model(1'b0, 1'b1, 8'd3, $urandom, "fill wr");
        chk("full3", {31'b0, bus.file_full[3]}, 32'h1);
        run_model(1'b0, 1'b1, 8'd3, 32'h1717, "overflow");
        for (int i = 0; i < 16; i++) run_model(1'b1, 1'b0, 8'd3, 32'h0, "drain rd");
        run_model(1'b1, 1'b0, 8'd3, 32'h0, "underflow");

        // A held read level produces exactly one pop.
        word = $urandom;
        run_model(1'b0, 1'b1, 8'd0, word, "hold prep");
        run_model(1'b0, 1'b1, 8'd0, word + 1, "hold prep2");
        @(posedge wb_clk); #1;
        bus.file_num = 8'd0; bus.file_read = 1'b1;
        act = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge wb_clk);
            if (bus.file_active) act++;
        end
        bus.file_read = 1'b0;
        m_rdata = model_q[0].pop_front();
        chk("hold active", act, 3);
        chk("hold rdata", bus.file_read_data, m_rdata);
        chk("hold empty", {28'b0, bus.file_empty}, {28'b0, m_empty()});

        // Reset asserted while the read sits in RD_DATA.
        run_model(1'b0, 1'b1, 8'd1, 32'h1234_5678, "rst prep");
        @(posedge wb_clk); #1;
        bus.file_num = 8'd1; bus.file_read = 1'b1;
        @(posedge wb_clk);
        @(posedge wb_clk); #2;
        wb_rst_n = 1'b0; bus.file_read = 1'b0;
        #1;
        chk("rst active", {31'b0, bus.file_active}, 32'h0);
        chk("rst rdata", bus.file_read_data, 32'h0);
        chk("rst error", {31'b0, bus.file_error}, 32'h0);
        chk("rst empty", {28'b0, bus.file_empty}, 32'hF);
        @(negedge wb_clk);
        wb_rst_n = 1'b1;
        for (int f = 0; f < NF; f++) model_q[f].delete();
        m_rdata = 32'h0; m_err = 1'b0;

        // Clear during the WR cycle drops the write.
        run_model(1'b0, 1'b1, 8'd2, 32'hCAFE_0002, "clr prep");
        @(posedge wb_clk); #1;
        bus.file_num = 8'd0; bus.file_write_data = 32'hBAD0_BAD0; bus.file_write = 1'b1;
        @(posedge wb_clk); #1;
        bus.file_clear = 1'b1;
        @(posedge wb_clk); #1;
        bus.file_clear = 1'b0; bus.file_write = 1'b0;
        for (int f = 0; f < NF; f++) model_q[f].delete();
        @(negedge wb_clk);
        chk("clr empty", {28'b0, bus.file_empty}, 32'hF);
        chk("clr active", {31'b0, bus.file_active}, 32'h0);
        chk("clr error", {31'b0, bus.file_error}, 32'h0);
        run_model(1'b1, 1'b0, 8'd0, 32'h0, "clr rd");

        // Random traffic, including invalid file numbers and colliding edges.
        for (int n = 0; n < 300; n++) begin
            int op;
            op = $urandom_range(0, 19);
            if (op < 10)      run_model(1'b0, 1'b1, 8'($urandom_range(0, 4)), $urandom, "rand wr");
            else if (op < 18) run_model(1'b1, 1'b0, 8'($urandom_range(0, 4)), 32'h0, "rand rd");
            else if (op < 19) run_model(1'b1, 1'b1, 8'($urandom_range(0, 3)), $urandom, "rand both");
            else              pulse_clear();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
